// File: rtl/operand_seq_sm.sv
// Supervisory sequencer for the switch/LED arithmetic demos: loads operands from
// the switches, kicks the arithmetic core, then pages its results out on the LEDs.
module operand_seq_sm #(
  parameter int WORD_W       = 8,
  parameter int NUM_OPERANDS = 4,
  parameter int NUM_RESULTS  = 2
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [WORD_W-1:0]                                 sw_data,
  input  logic                                              handshake,
  input  logic                                              res_valid,
  input  logic [NUM_RESULTS*WORD_W-1:0]                     results,
  output logic [NUM_OPERANDS*WORD_W-1:0]                    operands,
  output logic                                              start,
  output logic [WORD_W-1:0]                                 led,
  output logic [$clog2((NUM_OPERANDS > 2) ? NUM_OPERANDS : 2)-1:0] op_idx,
  output logic                                              busy,
  output logic [2:0]                                        state_dbg
);

  localparam int OP_IDX_W = $clog2((NUM_OPERANDS > 2) ? NUM_OPERANDS : 2);
  localparam int DISP_W   = $clog2((NUM_RESULTS > 2) ? NUM_RESULTS : 2);
  localparam logic [OP_IDX_W-1:0] LAST_OP  = OP_IDX_W'(NUM_OPERANDS - 1);
  localparam logic [DISP_W-1:0]   LAST_RES = DISP_W'(NUM_RESULTS - 1);

  typedef enum logic [2:0] {
    S_LOAD     = 3'd0,
    S_LOAD_REL = 3'd1,
    S_START    = 3'd2,
    S_WAIT_RES = 3'd3,
    S_DISP     = 3'd4
  } state_t;

  // Core interface: start is a one-cycle request; the core answers with a
  // one-cycle res_valid strobe, accepted only while waiting (from the cycle
  // after start onward). There is no back-pressure in either direction.

  state_t                         state, state_n;
  logic [OP_IDX_W-1:0]            op_idx_n;
  logic [DISP_W-1:0]              disp_idx, disp_n;
  logic [NUM_RESULTS*WORD_W-1:0]  res_q, res_n;
  logic [WORD_W-1:0]              led_d;
  logic                           capture, latch_res;
  logic                           hs_sync1, hs_sync2, hs_prev;
  logic                           hs_rise, hs_fall;

  // Sync and edge flops reset high so a switch left on through reset is not a rise.
  assign hs_rise = hs_sync2 & ~hs_prev;
  assign hs_fall = ~hs_sync2 & hs_prev;

  assign busy      = (state == S_START) || (state == S_WAIT_RES);
  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    op_idx_n  = op_idx;
    disp_n    = disp_idx;
    capture   = 1'b0;
    latch_res = 1'b0;
    case (state)
      S_LOAD: begin
        if (hs_rise) begin
          capture = 1'b1;
          state_n = S_LOAD_REL;
        end
      end
      S_LOAD_REL: begin
        if (hs_fall) begin
          if (op_idx == LAST_OP) begin
            op_idx_n = '0;
            state_n  = S_START;
          end else begin
            op_idx_n = op_idx + OP_IDX_W'(1);
            state_n  = S_LOAD;
          end
        end
      end
      S_START: state_n = S_WAIT_RES;
      S_WAIT_RES: begin
        if (res_valid) begin
          latch_res = 1'b1;
          disp_n    = '0;
          state_n   = S_DISP;
        end
      end
      S_DISP: begin
        if (hs_rise || hs_fall) begin
          if (disp_idx == LAST_RES) begin
            disp_n  = '0;
            state_n = S_LOAD;
          end else begin
            disp_n = disp_idx + DISP_W'(1);
          end
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  // led is registered from next-state values so it lines up with the state.
  always_comb begin
    res_n = latch_res ? results : res_q;
    led_d = '0;
    if (state_n == S_DISP) begin
      for (int j = 0; j < NUM_RESULTS; j++) begin
        if (disp_n == DISP_W'(j)) led_d = res_n[j*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LOAD;
      op_idx   <= '0;
      disp_idx <= '0;
      operands <= '0;
      res_q    <= '0;
      start    <= 1'b0;
      led      <= '0;
      hs_sync1 <= 1'b1;
      hs_sync2 <= 1'b1;
      hs_prev  <= 1'b1;
    end else begin
      hs_sync1 <= handshake;
      hs_sync2 <= hs_sync1;
      hs_prev  <= hs_sync2;
      state    <= state_n;
      op_idx   <= op_idx_n;
      disp_idx <= disp_n;
      res_q    <= res_n;
      start    <= (state_n == S_START);
      led      <= led_d;
      if (capture) begin
        for (int i = 0; i < NUM_OPERANDS; i++) begin
          if (op_idx == OP_IDX_W'(i)) operands[i*WORD_W +: WORD_W] <= sw_data;
        end
      end
    end
  end

endmodule
